// File: rtl/stdp_weight_writer_pkg.sv
// Shared constants and types for the STDP weight writer: weight format, learning
// rates, clamp limits, FSM states and pass modes.
package stdp_weight_writer_pkg;

    localparam int M        = 784;
    localparam int W        = 32;
    localparam int AW       = 10;
    localparam int FX_SCALE = 4096;
    localparam int AP       = 410;
    localparam int AM       = 205;
    localparam int WMAX     = 6144;
    localparam int WMIN     = -4915;

    typedef logic signed [W-1:0] weight_t;

    typedef enum logic {
        MODE_LTP,
        MODE_DEC
    } learn_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_t;

endpackage

// File: rtl/stdp_weight_writer_if.sv
// Port-B bus of a neuron's dual-port weight RAM: registered read plus single write.
interface stdp_weight_writer_if;
    import stdp_weight_writer_pkg::*;

    logic [AW-1:0] rd_addr;
    weight_t       rd_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    weight_t       wr_data;

    modport master (output rd_addr, wr_en, wr_addr, wr_data, input rd_data);
    modport slave  (input rd_addr, wr_en, wr_addr, wr_data, output rd_data);

endinterface

// File: rtl/stdp_weight_writer_alu.sv
// wt_update_alu: combinational STDP weight update with saturating clamp to [WMIN,WMAX].
// One guard bit keeps the add/subtract from wrapping before the clamp sees it.
module wt_update_alu
    import stdp_weight_writer_pkg::*;
(
    input  weight_t     w,
    input  logic        elig_bit,
    input  learn_mode_t mode,
    output weight_t     w_new
);

    localparam logic signed [W:0] AP_X   = (W+1)'(AP);
    localparam logic signed [W:0] AM_X   = (W+1)'(AM);
    localparam logic signed [W:0] WMAX_X = (W+1)'(WMAX);
    localparam logic signed [W:0] WMIN_X = (W+1)'(WMIN);

    logic signed [W:0] delta;
    logic signed [W:0] sum;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        delta = '0;
        w_new = '0;
        unique case (mode)
            MODE_LTP: delta = elig_bit ? AP_X : -AM_X;
            MODE_DEC: delta = elig_bit ? -AM_X : '0;
            default:  delta = '0;
        endcase
        sum = {w[W-1], w} + delta;
        if (sum > WMAX_X)
            w_new = W'(WMAX);
        else if (sum < WMIN_X)
            w_new = W'(WMIN);
        else
            w_new = sum[W-1:0];
    end

endmodule

// File: rtl/stdp_weight_writer.sv
// STDP weight writer: walks one neuron's weights on RAM port B and writes back
// LTP or depression updates gated by per-input eligibility bits.
module stdp_weight_writer
    import stdp_weight_writer_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start_core_img,
    input  logic         TU_incre,
    input  logic [M-1:0] spike_ip_nub,
    input  logic         learn_req,
    input  logic         dec_req,
    output logic         busy,
    output logic         done,
    stdp_weight_writer_if.master ram
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(M - 1);

    state_t        state;
    learn_mode_t   mode;
    logic          drain_cnt;
    logic [M-1:0]  elig;
    logic          s1_valid;
    logic [AW-1:0] s1_addr;
    weight_t       alu_w;

    // Stage 1 holds the address whose read data is on rd_data this cycle.
    wt_update_alu u_alu (
        .w        (ram.rd_data),
        .elig_bit (elig[s1_addr]),
        .mode     (mode),
        .w_new    (alu_w)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every reader sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            mode        <= MODE_LTP;
            drain_cnt   <= 1'b0;
            elig        <= '0;
            s1_valid    <= 1'b0;
            s1_addr     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            ram.rd_addr <= '0;
            ram.wr_en   <= 1'b0;
            ram.wr_addr <= '0;
            ram.wr_data <= '0;
        end else if (start_core_img) begin
            // Abort flushes the pipeline; writes already on the bus stand.
            state       <= ST_IDLE;
            drain_cnt   <= 1'b0;
            elig        <= '0;
            s1_valid    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            ram.rd_addr <= '0;
            ram.wr_en   <= 1'b0;
        end else begin
            done      <= 1'b0;
            s1_valid  <= (state == ST_RUN);
            s1_addr   <= ram.rd_addr;
            ram.wr_en <= s1_valid;
            if (s1_valid) begin
                ram.wr_addr <= s1_addr;
                ram.wr_data <= alu_w;
            end

            unique case (state)
                ST_IDLE: begin
                    if (learn_req || dec_req) begin
                        mode        <= learn_req ? MODE_LTP : MODE_DEC;
                        state       <= ST_RUN;
                        busy        <= 1'b1;
                        ram.rd_addr <= '0;
                    end
                end
                ST_RUN: begin
                    if (ram.rd_addr == LAST_ADDR) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= 1'b0;
                    end else begin
                        ram.rd_addr <= ram.rd_addr + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // Clear on the done cycle beats a coincident TU; frozen while a pass runs.
            if (done)
                elig <= '0;
            else if (TU_incre && !busy)
                elig <= elig | spike_ip_nub;
        end
    end

endmodule

// File: tb/tb_stdp_weight_writer.sv
// Self-checking bench for stdp_weight_writer: registered-read RAM model, a vector
// table run through LTP and DEC passes, and directed multi-cycle corner cases.
module tb_stdp_weight_writer;
    import stdp_weight_writer_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_core_img;
    logic         TU_incre;
    logic [M-1:0] spike_ip_nub;
    logic         learn_req;
    logic         dec_req;
    logic         busy;
    logic         done;

    stdp_weight_writer_if ram_bus ();

    stdp_weight_writer dut (
        .clk            (clk),
        .rst            (rst),
        .start_core_img (start_core_img),
        .TU_incre       (TU_incre),
        .spike_ip_nub   (spike_ip_nub),
        .learn_req      (learn_req),
        .dec_req        (dec_req),
        .busy           (busy),
        .done           (done),
        .ram            (ram_bus)
    );

    always #5 clk = ~clk;

    // RAM model with bench-side fill/poke for initialisation.
    weight_t       mem [M];
    logic          fill_en = 1'b0;
    weight_t       fill_val = '0;
    logic          poke_en = 1'b0;
    logic [AW-1:0] poke_addr = '0;
    weight_t       poke_data = '0;

    always @(posedge clk) begin
        if (fill_en)
            for (int i = 0; i < M; i++) mem[i] <= fill_val;
        else if (poke_en)
            mem[poke_addr] <= poke_data;
        if (ram_bus.wr_en) mem[ram_bus.wr_addr] <= ram_bus.wr_data;
        ram_bus.rd_data <= mem[ram_bus.rd_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: cumulative counts and last-seen event cycles, sampled mid-cycle.
    int   wr_total = 0, done_total = 0;
    int   wr_rise = -1, last_wr = -1, busy_rise = -1, busy_last = -1, done_cyc = -1;
    logic prev_busy = 1'b0, prev_wr = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            if (busy && !prev_busy) busy_rise = cyc;
            if (busy) busy_last = cyc;
            if (ram_bus.wr_en && !prev_wr) wr_rise = cyc;
            if (ram_bus.wr_en) begin
                last_wr = cyc;
                wr_total++;
            end
            if (done) begin
                done_total++;
                done_cyc = cyc;
            end
            prev_busy = busy;
            prev_wr   = ram_bus.wr_en;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic fill(input weight_t v);
        @(negedge clk); fill_en = 1'b1; fill_val = v;
        @(negedge clk); fill_en = 1'b0;
    endtask

    task automatic poke(input int a, input weight_t v);
        @(negedge clk); poke_en = 1'b1; poke_addr = AW'(a); poke_data = v;
        @(negedge clk); poke_en = 1'b0;
    endtask

    task automatic set_elig(input logic [M-1:0] mask);
        @(negedge clk); spike_ip_nub = mask; TU_incre = 1'b1;
        @(negedge clk); spike_ip_nub = '0;   TU_incre = 1'b0;
    endtask

    task automatic run_req(input bit l, input bit d, output int t);
        @(negedge clk); learn_req = l; dec_req = d; t = cyc;
        @(negedge clk); learn_req = 1'b0; dec_req = 1'b0;
    endtask

    task automatic goto_cycle(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic wait_done(input int d0);
        int i = 0;
        while (done_total == d0 && i < M + 50) begin
            @(posedge clk);
            i++;
        end
        if (done_total == d0) check("done_timeout", 0, 1);
        repeat (2) @(posedge clk);
    endtask

    function automatic int count_not(input weight_t v, input int lo, input int skip);
        int n = 0;
        for (int i = lo; i < M; i++)
            if (i != skip && mem[i] != v) n++;
        return n;
    endfunction

    typedef struct {
        int      addr;
        weight_t init;
        bit      el;
        weight_t exp_ltp;
        weight_t exp_dec;
    } row_t;

    row_t rows [11];

    initial begin
        int t, d0, w0;
        logic [M-1:0] mask;

        rows[0]  = '{0,   6000,          1'b1, 6144,  5795};
        rows[1]  = '{1,   -4900,         1'b0, -4915, -4900};
        rows[2]  = '{2,   1000,          1'b1, 1410,  795};
        rows[3]  = '{3,   1000,          1'b0, 795,   1000};
        rows[4]  = '{4,   6144,          1'b1, 6144,  5939};
        rows[5]  = '{5,   -4915,         1'b0, -4915, -4915};
        rows[6]  = '{6,   0,             1'b1, 410,   -205};
        rows[7]  = '{7,   -4800,         1'b1, -4390, -4915};
        rows[8]  = '{8,   6100,          1'b0, 5895,  6100};
        rows[9]  = '{9,   32'sh7fffffff, 1'b1, 6144,  6144};
        rows[10] = '{783, 32'sh80000000, 1'b1, -4915, -4915};

        rst = 1'b1; start_core_img = 1'b0; TU_incre = 1'b0; spike_ip_nub = '0;
        learn_req = 1'b0; dec_req = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy",    busy, 0);
        check("rst_done",    done, 0);
        check("rst_wr_en",   ram_bus.wr_en, 0);
        check("rst_rd_addr", ram_bus.rd_addr, 0);
        check("rst_wr_addr", ram_bus.wr_addr, 0);
        check("rst_wr_data", ram_bus.wr_data, 0);
        rst = 1'b0;

        // Basic LTP pass with a single eligible input, full timing profile.
        fill(1000);
        mask = '0; mask[3] = 1'b1;
        set_elig(mask);
        d0 = done_total; w0 = wr_total;
        run_req(1'b1, 1'b0, t);
        wait_done(d0);
        check("t1_done_cnt",   done_total - d0, 1);
        check("t1_done_cyc",   done_cyc, t + M + 3);
        check("t1_busy_rise",  busy_rise, t + 1);
        check("t1_busy_last",  busy_last, t + M + 2);
        check("t1_first_wr",   wr_rise, t + 3);
        check("t1_last_wr",    last_wr, t + M + 2);
        check("t1_wr_cnt",     wr_total - w0, M);
        check("t1_addr3",      mem[3], 1410);
        check("t1_others_bad", count_not(795, 0, 3), 0);

        // Table: same initial words through an LTP pass, then a DEC pass.
        for (int pass = 0; pass < 2; pass++) begin
            fill(0);
            mask = '0;
            foreach (rows[i]) begin
                poke(rows[i].addr, rows[i].init);
                mask[rows[i].addr] = rows[i].el;
            end
            set_elig(mask);
            d0 = done_total;
            run_req(pass == 0, pass == 1, t);
            wait_done(d0);
            foreach (rows[i])
                check($sformatf("tbl_%s_addr%0d", pass == 0 ? "ltp" : "dec", rows[i].addr),
                      mem[rows[i].addr], pass == 0 ? rows[i].exp_ltp : rows[i].exp_dec);
        end

        // learn_req and dec_req together -> one LTP pass; later requests while busy ignored.
        fill(1000);
        d0 = done_total; w0 = wr_total;
        run_req(1'b1, 1'b1, t);
        goto_cycle(t + 50); dec_req = 1'b1;   @(negedge clk); dec_req = 1'b0;
        goto_cycle(t + 60); learn_req = 1'b1; @(negedge clk); learn_req = 1'b0;
        wait_done(d0);
        repeat (20) @(posedge clk);
        check("t3_done_cnt", done_total - d0, 1);
        check("t3_wr_cnt",   wr_total - w0, M);
        check("t3_addr0",    mem[0], 795);
        check("t3_addr_last", mem[M-1], 795);
        check("t3_busy_idle", busy, 0);

        // Depression pass with elig[5].
        fill(0);
        mask = '0; mask[5] = 1'b1;
        set_elig(mask);
        d0 = done_total; w0 = wr_total;
        run_req(1'b0, 1'b1, t);
        wait_done(d0);
        check("t4_addr5",      mem[5], -205);
        check("t4_others_bad", count_not(0, 0, 5), 0);
        check("t4_wr_cnt",     wr_total - w0, M);

        // Abort at t+100: writes 0..97 stand, no done, eligibility cleared.
        fill(1000);
        mask = '0; mask[200] = 1'b1;
        set_elig(mask);
        d0 = done_total; w0 = wr_total;
        run_req(1'b1, 1'b0, t);
        goto_cycle(t + 100); start_core_img = 1'b1;
        @(negedge clk); start_core_img = 1'b0;
        repeat (40) @(posedge clk);
        check("t5_no_done",   done_total - d0, 0);
        check("t5_busy",      busy, 0);
        check("t5_wr_cnt",    wr_total - w0, 98);
        check("t5_last_wr",   last_wr, t + 100);
        check("t5_addr97",    mem[97], 795);
        check("t5_tail_bad",  count_not(1000, 98, -1), 0);
        d0 = done_total;
        run_req(1'b0, 1'b1, t);
        wait_done(d0);
        check("t5_elig_clr",  mem[200], 1000);
        check("t5_addr0_dec", mem[0], 795);

        // start_core_img with learn_req: request dropped.
        w0 = wr_total;
        @(negedge clk); start_core_img = 1'b1; learn_req = 1'b1;
        @(negedge clk); start_core_img = 1'b0; learn_req = 1'b0;
        repeat (10) @(posedge clk);
        check("abort_req_busy", busy, 0);
        check("abort_req_wr",   wr_total - w0, 0);

        // Spike on the done cycle is lost; the following TU registers normally.
        fill(0);
        d0 = done_total;
        run_req(1'b0, 1'b1, t);
        goto_cycle(t + M + 3);
        check("t6_done_now", done, 1);
        spike_ip_nub = '0; spike_ip_nub[7] = 1'b1; TU_incre = 1'b1;
        @(negedge clk);
        spike_ip_nub = '0; spike_ip_nub[8] = 1'b1;
        @(negedge clk);
        spike_ip_nub = '0; TU_incre = 1'b0;
        d0 = done_total;
        run_req(1'b0, 1'b1, t);
        wait_done(d0);
        check("t6_lost_spike", mem[7], 0);
        check("t6_next_spike", mem[8], -205);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
